// File: rtl/mcu_subsys_pkg.sv
// mcu_subsys_pkg: shared FSM state type and constants for the MCU subsystem bus decoder.
package mcu_subsys_pkg;
  localparam int MAX_TARGETS = 8;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, ACTIVE, ERR_RESP} state_t;
  function automatic logic [MAX_TARGETS-1:0] onehot(input logic [2:0] idx);
    return MAX_TARGETS'(1) << idx;
  endfunction
endpackage

// File: rtl/mcu_subsys_bus_decoder_if.sv
// mcu_subsys_bus_decoder_if: CPU-side request/response bus plus the fan-out target bus.
interface mcu_subsys_bus_decoder_if #(parameter int N = 3);
  logic          cpu_mem_valid;
  logic          cpu_mem_we;
  logic [31:0]   cpu_mem_addr;
  logic [31:0]   cpu_mem_wdata;
  logic [3:0]    cpu_mem_be;
  logic          cpu_mem_ready;
  logic          cpu_mem_err;
  logic [31:0]   cpu_mem_rdata;
  logic [N-1:0]  tgt_mem_valid;
  logic [31:0]   tgt_mem_addr;
  logic [31:0]   tgt_mem_wdata;
  logic [3:0]    tgt_mem_wstrb;
  logic [N-1:0]  tgt_mem_ready;
  logic [N*32-1:0] tgt_mem_rdata;
  modport master (
    output cpu_mem_valid, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata, cpu_mem_be,
    output tgt_mem_ready, tgt_mem_rdata,
    input  cpu_mem_ready, cpu_mem_err, cpu_mem_rdata,
    input  tgt_mem_valid, tgt_mem_addr, tgt_mem_wdata, tgt_mem_wstrb
  );
  modport slave (
    input  cpu_mem_valid, cpu_mem_we, cpu_mem_addr, cpu_mem_wdata, cpu_mem_be,
    input  tgt_mem_ready, tgt_mem_rdata,
    output cpu_mem_ready, cpu_mem_err, cpu_mem_rdata,
    output tgt_mem_valid, tgt_mem_addr, tgt_mem_wdata, tgt_mem_wstrb
  );
endinterface

// File: rtl/mcu_subsys_addr_decode.sv
// mcu_subsys_addr_decode: masked base-address match, lowest matching index wins.
module mcu_subsys_addr_decode #(
  parameter int NUM_TARGETS = 3,
  parameter logic [NUM_TARGETS*32-1:0] TGT_BASE = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_TARGETS*32-1:0] TGT_MASK = {3{32'hC000_0000}}
) (
  input  logic [31:0] addr,
  output logic        hit,
  output logic [2:0]  idx
);
  // Scanning downward lets the lowest matching index overwrite higher ones.
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--)
      if ((addr & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        idx = 3'(i);
      end
  end
endmodule

// File: rtl/mcu_subsys_bus_decoder.sv
// mcu_subsys_bus_decoder: routes one CPU request at a time to an address-decoded target,
// with timeout, decode-error responses and error bookkeeping.
module mcu_subsys_bus_decoder
  import mcu_subsys_pkg::*;
#(
  parameter int NUM_TARGETS = 3,
  parameter logic [NUM_TARGETS*32-1:0] TGT_BASE = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_TARGETS*32-1:0] TGT_MASK = {3{32'hC000_0000}},
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        rst,
  mcu_subsys_bus_decoder_if.slave bus,
  output logic [15:0] bus_err_count,
  output logic [31:0] last_err_addr
);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [2:0] sel, hit_idx;
  logic hit, sel_ready, expire;
  logic [31:0] cnt;
  logic [MAX_TARGETS-1:0] rdy_ext;
  logic [MAX_TARGETS*32-1:0] rd_ext;
  mcu_subsys_addr_decode #(
    .NUM_TARGETS(NUM_TARGETS), .TGT_BASE(TGT_BASE), .TGT_MASK(TGT_MASK)
  ) u_decode (
    .addr(bus.cpu_mem_addr), .hit(hit), .idx(hit_idx)
  );
  assign bus.tgt_mem_addr  = bus.cpu_mem_addr;
  assign bus.tgt_mem_wdata = bus.cpu_mem_wdata;
  assign bus.tgt_mem_wstrb = bus.cpu_mem_we ? bus.cpu_mem_be : 4'h0;
  // Widen to MAX_TARGETS so the 3-bit latched index never selects out of range.
  assign rdy_ext   = MAX_TARGETS'(bus.tgt_mem_ready);
  assign rd_ext    = (MAX_TARGETS*32)'(bus.tgt_mem_rdata);
  assign sel_ready = rdy_ext[sel];
  assign expire    = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= 3'd0;
      cnt           <= 32'd0;
      bus_err_count <= 16'd0;
      last_err_addr <= 32'd0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        sel <= hit_idx;
        cnt <= 32'd0;
      end else if (state == ACTIVE) begin
        cnt <= cnt + 32'd1;
      end
      if (state == ERR_RESP) begin
        bus_err_count <= (&bus_err_count) ? bus_err_count : bus_err_count + 16'd1;
        last_err_addr <= bus.cpu_mem_addr;
      end
    end
  end
  // Outputs are held quiet while rst is high so a reset never produces a response.
  always_comb begin
    state_n           = state;
    bus.tgt_mem_valid = '0;
    bus.cpu_mem_ready = 1'b0;
    bus.cpu_mem_err   = 1'b0;
    bus.cpu_mem_rdata = 32'd0;
    if (!rst) begin
      case (state)
        IDLE:
          if (bus.cpu_mem_valid) state_n = hit ? ACTIVE : ERR_RESP;
        ACTIVE:
          if (!bus.cpu_mem_valid) state_n = IDLE;
          else begin
            bus.tgt_mem_valid = NUM_TARGETS'(onehot(sel));
            bus.cpu_mem_ready = sel_ready;
            bus.cpu_mem_rdata = sel_ready ? rd_ext[{sel, 5'd0} +: 32] : 32'd0;
            state_n           = sel_ready ? IDLE : (expire ? ERR_RESP : ACTIVE);
          end
        ERR_RESP: begin
          bus.cpu_mem_ready = 1'b1;
          bus.cpu_mem_err   = 1'b1;
          bus.cpu_mem_rdata = ERR_RDATA;
          state_n           = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcu_subsys_bus_decoder.sv
// tb_mcu_subsys_bus_decoder: directed transactions checked every cycle against a
// transaction-level expectation model, plus literal pins on key results.
module tb_mcu_subsys_bus_decoder;
  localparam int N  = 3;
  localparam int TO = 4;
  localparam logic [N*32-1:0] BASE = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK = {3{32'hC000_0000}};
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic sys_clk = 1'b0;
  logic rst;
  logic [15:0] bus_err_count;
  logic [31:0] last_err_addr;
  always #5 sys_clk = ~sys_clk;

  mcu_subsys_bus_decoder_if #(.N(N)) bus ();

  mcu_subsys_bus_decoder #(
    .NUM_TARGETS(N), .TGT_BASE(BASE), .TGT_MASK(MASK),
    .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .bus(bus),
    .bus_err_count(bus_err_count), .last_err_addr(last_err_addr)
  );

  int vectors = 0;
  int miscompares = 0;
  logic        e_chk = 1'b0, e_tv_chk;
  logic [2:0]  e_tv;
  logic        e_rdy, e_err;
  logic [31:0] e_rdata;
  logic [15:0] m_cnt;
  logic [31:0] m_last;
  logic [31:0] trd [N];
  int          tv_cycles = 0;
  int          rsp_seen = 0;
  logic [31:0] rsp_rdata = 32'd0;
  logic        rsp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return i;
    return -1;
  endfunction

  always @(negedge sys_clk) begin
    if (e_chk) begin
      if (e_tv_chk) chk("tgt_valid", 32'(bus.tgt_mem_valid), 32'(e_tv));
      chk("cpu_ready", 32'(bus.cpu_mem_ready), 32'(e_rdy));
      chk("cpu_err", 32'(bus.cpu_mem_err), 32'(e_err));
      chk("cpu_rdata", bus.cpu_mem_rdata, e_rdata);
      chk("tgt_addr", bus.tgt_mem_addr, bus.cpu_mem_addr);
      chk("tgt_wdata", bus.tgt_mem_wdata, bus.cpu_mem_wdata);
      chk("tgt_wstrb", 32'(bus.tgt_mem_wstrb), bus.cpu_mem_we ? 32'(bus.cpu_mem_be) : 32'd0);
      chk("err_count", 32'(bus_err_count), 32'(m_cnt));
      chk("last_err_addr", last_err_addr, m_last);
    end
    if (bus.tgt_mem_valid != '0) tv_cycles++;
    if (bus.cpu_mem_ready) begin
      rsp_seen++;
      rsp_rdata = bus.cpu_mem_rdata;
      rsp_err   = bus.cpu_mem_err;
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_cyc(input logic tvc, input logic [2:0] tv, input logic rdy,
                            input logic err, input logic [31:0] rd);
    e_chk = 1'b1; e_tv_chk = tvc; e_tv = tv; e_rdy = rdy; e_err = err; e_rdata = rd;
  endtask

  task automatic err_cycle();
    bus.tgt_mem_ready = '0;
    expect_cyc(1'b1, 3'b000, 1'b1, 1'b1, ERRD);
    step();
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_last = bus.cpu_mem_addr;
  endtask

  task automatic idle_cycle();
    bus.cpu_mem_valid = 1'b0;
    bus.tgt_mem_ready = '0;
    expect_cyc(1'b1, 3'b000, 1'b0, 1'b0, 32'd0);
    step();
  endtask

  // wait_n: ready on the wait_n-th cycle the target sees valid (0 = never).
  task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                     input logic [31:0] wd, input int wait_n, input bit scramble, input bit tail);
    int t;
    logic rdy;
    t = decode(a);
    bus.cpu_mem_valid = 1'b1; bus.cpu_mem_we = we; bus.cpu_mem_addr = a;
    bus.cpu_mem_be = be; bus.cpu_mem_wdata = wd; bus.tgt_mem_ready = '0;
    bus.tgt_mem_rdata = {trd[2], trd[1], trd[0]};
    expect_cyc(1'b1, 3'b000, 1'b0, 1'b0, 32'd0);
    step();
    if (t < 0) err_cycle();
    else begin
      for (int k = 1; k <= TO; k++) begin
        if (scramble && k >= 2) bus.cpu_mem_addr = 32'h8000_0100;
        rdy = (k == wait_n);
        bus.tgt_mem_ready = rdy ? 3'(1 << t) : ~3'(1 << t);
        expect_cyc(1'b1, 3'(1 << t), rdy, 1'b0, rdy ? trd[t] : 32'd0);
        step();
        if (rdy) break;
        if (k == TO) err_cycle();
      end
    end
    if (tail) idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0;
    trd[0] = 32'h0A0A_0A0A; trd[1] = 32'h1234_5678; trd[2] = 32'h5555_AAAA;
    m_cnt = 16'd0; m_last = 32'd0;
    rst = 1'b1;
    bus.cpu_mem_valid = 1'b0; bus.cpu_mem_we = 1'b0; bus.cpu_mem_addr = 32'd0;
    bus.cpu_mem_wdata = 32'd0; bus.cpu_mem_be = 4'h0; bus.tgt_mem_ready = '0;
    bus.tgt_mem_rdata = '0;
    step(); step();
    expect_cyc(1'b1, 3'b000, 1'b0, 1'b0, 32'd0);
    step();
    rst = 1'b0;
    idle_cycle();
    // Read from target 1 with three-cycle latency.
    t0 = tv_cycles; r0 = rsp_seen;
    txn(32'h4000_0010, 1'b0, 4'hF, 32'd0, 3, 1'b0, 1'b1);
    chk("rd_valid_cycles", 32'(tv_cycles - t0), 32'd3);
    chk("rd_rsp_count", 32'(rsp_seen - r0), 32'd1);
    chk("rd_rdata_lit", rsp_rdata, 32'h1234_5678);
    chk("rd_err_lit", 32'(rsp_err), 32'd0);
    // Write to target 0 with partial strobes.
    txn(32'h0000_0004, 1'b1, 4'b0011, 32'hCAFE_F00D, 1, 1'b0, 1'b1);
    // Unmapped address.
    t0 = tv_cycles;
    txn(32'hC000_0000, 1'b0, 4'hF, 32'd0, 1, 1'b0, 1'b1);
    chk("dec_err_valid_cycles", 32'(tv_cycles - t0), 32'd0);
    chk("dec_err_rdata_lit", rsp_rdata, 32'hDEAD_BEEF);
    chk("dec_err_flag_lit", 32'(rsp_err), 32'd1);
    chk("dec_err_count_lit", 32'(bus_err_count), 32'd1);
    chk("dec_err_addr_lit", last_err_addr, 32'hC000_0000);
    // Target never responds.
    t0 = tv_cycles;
    txn(32'h8000_0020, 1'b0, 4'hF, 32'd0, 0, 1'b0, 1'b1);
    chk("timeout_valid_cycles", 32'(tv_cycles - t0), 32'd4);
    chk("timeout_count_lit", 32'(bus_err_count), 32'd2);
    chk("timeout_addr_lit", last_err_addr, 32'h8000_0020);
    // Ready on the expiry cycle.
    txn(32'h4000_0040, 1'b0, 4'hF, 32'd0, 4, 1'b0, 1'b1);
    chk("expiry_ready_err_lit", 32'(rsp_err), 32'd0);
    chk("expiry_ready_count_lit", 32'(bus_err_count), 32'd2);
    // Address changes mid-transaction, then a back-to-back request.
    txn(32'h4000_0000, 1'b1, 4'b1100, 32'h0102_0304, 3, 1'b1, 1'b0);
    txn(32'h0000_0100, 1'b0, 4'hF, 32'd0, 2, 1'b0, 1'b1);
    chk("b2b_rdata_lit", rsp_rdata, 32'h0A0A_0A0A);
    // Abort: valid drops while active; target ready is ignored.
    bus.cpu_mem_valid = 1'b1; bus.cpu_mem_we = 1'b0; bus.cpu_mem_addr = 32'h8000_0000;
    expect_cyc(1'b1, 3'b000, 1'b0, 1'b0, 32'd0);
    step();
    expect_cyc(1'b1, 3'b100, 1'b0, 1'b0, 32'd0);
    step();
    r0 = rsp_seen;
    bus.cpu_mem_valid = 1'b0; bus.tgt_mem_ready = 3'b100;
    expect_cyc(1'b1, 3'b000, 1'b0, 1'b0, 32'd0);
    step();
    idle_cycle();
    chk("abort_no_rsp", 32'(rsp_seen - r0), 32'd0);
    chk("abort_count_lit", 32'(bus_err_count), 32'd2);
    // Reset mid-transaction.
    bus.cpu_mem_valid = 1'b1; bus.cpu_mem_addr = 32'h4000_0008;
    expect_cyc(1'b1, 3'b000, 1'b0, 1'b0, 32'd0);
    step();
    expect_cyc(1'b1, 3'b010, 1'b0, 1'b0, 32'd0);
    step();
    r0 = rsp_seen;
    rst = 1'b1; bus.tgt_mem_ready = 3'b010;
    expect_cyc(1'b0, 3'b000, 1'b0, 1'b0, 32'd0);
    step();
    m_cnt = 16'd0; m_last = 32'd0;
    rst = 1'b0;
    idle_cycle();
    chk("rst_no_rsp", 32'(rsp_seen - r0), 32'd0);
    chk("rst_count_lit", 32'(bus_err_count), 32'd0);
    chk("rst_addr_lit", last_err_addr, 32'd0);
    // Normal operation after reset.
    txn(32'h8000_0004, 1'b0, 4'hF, 32'd0, 2, 1'b0, 1'b1);
    chk("post_rst_rdata_lit", rsp_rdata, 32'h5555_AAAA);
    e_chk = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mcu_subsys_bus_decoder.md
MCU_SUBSYS_BUS_DECODER -- requirements
Module: mcu_subsys_bus_decoder

Interface
REQ-001 Parameter NUM_TARGETS, default 3: number of downstream memory targets, range 1..8.
REQ-002 Parameter TGT_BASE, default {32'h8000_0000, 32'h4000_0000, 32'h0000_0000}: per-target base address, packed [NUM_TARGETS][32], index 0 in the LSBs.
REQ-003 Parameter TGT_MASK, default {3{32'hC000_0000}}: per-target compare mask, same packing as TGT_BASE.
REQ-004 Parameter TIMEOUT_CYCLES, default 256: cycles allowed for a target to respond; 0 disables the timeout.
REQ-005 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on an error response.
REQ-006 sys_clk  in  1  system clock; single clock domain.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 cpu_mem_valid / cpu_mem_we  in  1 / 1  CPU request strobe / write enable.
REQ-009 cpu_mem_addr / cpu_mem_wdata  in  32 / 32  CPU address / write data.
REQ-010 cpu_mem_be  in  4  CPU byte enables.
REQ-011 cpu_mem_ready / cpu_mem_err  out  1 / 1  response strobe / error flag, valid only while ready=1.
REQ-012 cpu_mem_rdata  out  32  response read data.
REQ-013 tgt_mem_valid  out  NUM_TARGETS  per-target request strobe, one-hot or zero.
REQ-014 tgt_mem_addr / tgt_mem_wdata / tgt_mem_wstrb  out  32 / 32 / 4  shared to all targets.
REQ-015 tgt_mem_ready  in  NUM_TARGETS  per-target response strobe.
REQ-016 tgt_mem_rdata  in  NUM_TARGETS*32  per-target read data, packed, index 0 in the LSBs.
REQ-017 bus_err_count  out  16  saturating count of error responses.
REQ-018 last_err_addr  out  32  address of the most recent error response.

Function
REQ-019 tgt_mem_addr/wdata SHALL be combinational pass-through of cpu_mem_addr/wdata; tgt_mem_wstrb SHALL equal cpu_mem_we ? cpu_mem_be : 4'h0.
REQ-020 Target i matches when (cpu_mem_addr & TGT_MASK[i]) == TGT_BASE[i]; on multiple matches the lowest index wins.
REQ-021 FSM states: IDLE, ACTIVE, ERR_RESP; reset state IDLE.
REQ-022 IDLE with cpu_mem_valid=1 and a match: latch the target index, go to ACTIVE, clear the timeout counter.
REQ-023 IDLE with cpu_mem_valid=1 and no match: go to ERR_RESP; no tgt_mem_valid bit is asserted.
REQ-024 ACTIVE: tgt_mem_valid[sel]=1; only the latched index selects ready/rdata; later address changes do not re-decode.
REQ-025 ACTIVE with tgt_mem_ready[sel]=1: same cycle cpu_mem_ready=1, cpu_mem_err=0, cpu_mem_rdata=tgt_mem_rdata[sel]; next state IDLE.
REQ-026 ACTIVE timeout: counter increments each cycle without ready; at count TIMEOUT_CYCLES-1 without ready, go to ERR_RESP and drop tgt_mem_valid.
REQ-027 Ready and timeout expiry in the same cycle: ready wins; no error is recorded.
REQ-028 ERR_RESP (one cycle): cpu_mem_ready=1, cpu_mem_err=1, cpu_mem_rdata=ERR_RDATA; bus_err_count increments, saturating at 16'hFFFF; last_err_addr captures cpu_mem_addr; next state IDLE.
REQ-029 cpu_mem_valid deasserted in ACTIVE: abort, drop tgt_mem_valid, go to IDLE, no response, no error count.
REQ-030 Ready from a non-selected target SHALL be ignored.
REQ-031 A new request SHALL be accepted no earlier than the cycle after a response; a back-to-back request costs one IDLE cycle.
REQ-032 Outside ACTIVE/ERR_RESP, cpu_mem_ready=0, cpu_mem_err=0, cpu_mem_rdata=0.

Reset
REQ-033 With rst=1 at a sys_clk edge: state IDLE, tgt_mem_valid=0, cpu_mem_ready=0, cpu_mem_err=0, timeout counter=0, bus_err_count=0, last_err_addr=0.
REQ-034 Reset mid-transaction SHALL drop tgt_mem_valid the next cycle and give no CPU response.

Structure
REQ-035 Package mcu_subsys_pkg SHALL hold the FSM state enum, the default ERR_RDATA constant, and the MAX_TARGETS=8 constant.
REQ-036 Sub-module mcu_subsys_addr_decode (combinational priority match producing hit and index) SHALL be instantiated once.

Verification
REQ-037 Read 0x4000_0010, SRAM ready after 3 cycles with rdata 0x1234_5678 -> tgt_mem_valid=3'b010 for 3 cycles; cpu_mem_ready coincident with target ready; rdata 0x1234_5678; err=0.
REQ-038 Write 0x0000_0004, we=1, be=4'b0011 -> tgt_mem_wstrb=4'b0011, tgt_mem_valid=3'b001; a read gives tgt_mem_wstrb=0.
REQ-039 Access 0xC000_0000 -> no tgt_mem_valid bit set; ready+err one cycle later; rdata 0xDEAD_BEEF; bus_err_count=1; last_err_addr=0xC000_0000.
REQ-040 Target never ready, TIMEOUT_CYCLES=4 -> tgt_mem_valid high 4 cycles, then ERR_RESP; count increments.
REQ-041 Target ready on the exact expiry cycle -> normal response, err=0, count unchanged.
REQ-042 rst pulse during ACTIVE -> tgt_mem_valid=0 next cycle; no cpu_mem_ready; counters at 0.
